// File: rtl/ika2151_noise_multi.sv
// rtl/ika2151_noise_multi.sv - multi-channel noise generator: divider, LFSR and signed amplitude stage per channel
module ika2151_noise_multi #(
  parameter int                CH     = 1,
  parameter int                NFRQ_W = 5,
  parameter int                LFSR_W = 17,
  parameter int                TAP_A  = 0,
  parameter int                TAP_B  = 3,
  parameter logic [LFSR_W-1:0] SEED   = '0,
  parameter int                OUT_W  = 14
) (
  input  logic                     i_EMUCLK,
  input  logic                     i_MRST,
  input  logic                     i_phi1_NCEN_n,
  input  logic                     i_CYCLE_12,
  input  logic [CH*NFRQ_W-1:0]     i_NFRQ,
  input  logic [CH-1:0]            i_NE,
  input  logic [CH*(OUT_W-1)-1:0]  i_LEVEL,
  output logic [CH-1:0]            o_NOISE_BIT,
  output logic [CH*OUT_W-1:0]      o_ACC_NOISE
);

  localparam int MAG_W = OUT_W - 1;

  logic tick;
  assign tick = i_CYCLE_12 & ~i_phi1_NCEN_n;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [NFRQ_W-1:0] cnt;
    logic [NFRQ_W-1:0] period;
    logic              step;
    logic [LFSR_W-1:0] lfsr;
    logic              fb;
    logic [OUT_W-1:0]  mag;
    logic [OUT_W-1:0]  acc;
    logic [OUT_W-1:0]  acc_nxt;

    // all-ones minus the code is simply its bitwise complement
    assign period = ~i_NFRQ[c*NFRQ_W +: NFRQ_W];
    // >= so a lowered period mid-count fires next tick instead of wrapping
    assign step   = (cnt >= period);
    assign fb     = (lfsr == '0) ? 1'b1 : (lfsr[TAP_A] ^ lfsr[TAP_B]);
    assign mag    = {1'b0, i_LEVEL[c*MAG_W +: MAG_W]};

    always_comb begin
      acc_nxt = '0;
      if (i_NE[c]) begin
        acc_nxt = lfsr[0] ? mag : -mag;
      end
    end

    always_ff @(posedge i_EMUCLK) begin
      if (i_MRST) begin
        cnt  <= '0;
        lfsr <= SEED;
        acc  <= '0;
      end else if (tick) begin
        acc <= acc_nxt;
        if (step) begin
          cnt  <= '0;
          lfsr <= {fb, lfsr[LFSR_W-1:1]};
        end else begin
          cnt <= cnt + NFRQ_W'(1);
        end
      end
    end

    assign o_NOISE_BIT[c]                 = lfsr[0];
    assign o_ACC_NOISE[c*OUT_W +: OUT_W]  = acc;
  end

endmodule

// File: tb/tb_ika2151_noise_multi.sv
// tb/tb_ika2151_noise_multi.sv - randomized bench with behavioural noise model for ika2151_noise_multi
module tb_ika2151_noise_multi;
  localparam int CH     = 2;
  localparam int NFRQ_W = 5;
  localparam int LFSR_W = 17;
  localparam int OUT_W  = 14;
  localparam int MAG_W  = OUT_W - 1;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    ncen_n;
  logic                    cyc12;
  logic [CH*NFRQ_W-1:0]    nfrq;
  logic [CH-1:0]           ne;
  logic [CH*MAG_W-1:0]     level;
  logic [CH-1:0]           noise_bit;
  logic [CH*OUT_W-1:0]     acc_noise;

  always #5 clk = ~clk;

  ika2151_noise_multi #(
    .CH(CH), .NFRQ_W(NFRQ_W), .LFSR_W(LFSR_W), .TAP_A(0), .TAP_B(3),
    .SEED(17'h0), .OUT_W(OUT_W)
  ) dut (
    .i_EMUCLK      (clk),
    .i_MRST        (rst),
    .i_phi1_NCEN_n (ncen_n),
    .i_CYCLE_12    (cyc12),
    .i_NFRQ        (nfrq),
    .i_NE          (ne),
    .i_LEVEL       (level),
    .o_NOISE_BIT   (noise_bit),
    .o_ACC_NOISE   (acc_noise)
  );

  int checks = 0;
  int passed = 0;
  bit cmp_en = 1'b0;

  // model: ticks elapsed since last step, LFSR value as an integer, held sample
  int m_since[CH];
  int m_lfsr[CH];
  int m_acc[CH];
  int m_steps[CH];

  function automatic int lfsr_next(int v);
    int fb;
    if (v == 0) fb = 1;
    else        fb = (v ^ (v >> 3)) & 1;
    return (v >> 1) | (fb << (LFSR_W - 1));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  always @(posedge clk) begin
    for (int c = 0; c < CH; c++) begin
      if (rst) begin
        m_since[c] = 0;
        m_lfsr[c]  = 0;
        m_acc[c]   = 0;
        m_steps[c] = 0;
      end else if (cyc12 && !ncen_n) begin
        int lev, per;
        lev = int'(level[c*MAG_W +: MAG_W]);
        if (!ne[c])             m_acc[c] = 0;
        else if (m_lfsr[c] & 1) m_acc[c] = lev;
        else                    m_acc[c] = (16384 - lev) & 16'h3FFF;
        per = 31 - int'(nfrq[c*NFRQ_W +: NFRQ_W]);
        if (m_since[c] >= per) begin
          m_since[c] = 0;
          m_lfsr[c]  = lfsr_next(m_lfsr[c]);
          m_steps[c]++;
        end else begin
          m_since[c]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int c = 0; c < CH; c++) begin
        chk($sformatf("bit_ch%0d", c), int'(noise_bit[c]), m_lfsr[c] & 1);
        chk($sformatf("acc_ch%0d", c), int'(acc_noise[c*OUT_W +: OUT_W]), m_acc[c]);
      end
    end
  end

  task automatic clk_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clk_n(1);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ncen_n = 1'b0; cyc12 = 1'b0;
    nfrq = '0; ne = '0; level = '0;
    clk_n(2);
    cmp_en = 1'b1;
    chk("reset_acc0", int'(acc_noise[0 +: OUT_W]), 0);
    chk("reset_acc1", int'(acc_noise[OUT_W +: OUT_W]), 0);
    chk("reset_bits", int'(noise_bit), 0);
    rst = 1'b0;

    // recovery from all-zero seed, then the shifted one walks down to bit 0
    nfrq = {5'd17, 5'd31}; ne = 2'b11; level = {13'h00AB, 13'h1FFF};
    cyc12 = 1'b1;
    clk_n(1);
    chk("first_acc", int'(acc_noise[0 +: OUT_W]), 'h2001);
    chk("model_lfsr", m_lfsr[0], 'h10000);
    clk_n(16);
    chk("bit_after_17", int'(noise_bit[0]), 1);
    clk_n(1);
    chk("acc_pos_full", int'(acc_noise[0 +: OUT_W]), 'h1FFF);

    // slowest rate with sparse ticks
    do_reset();
    nfrq = '0;
    for (int t = 0; t < 64; t++) begin
      cyc12 = 1'b1; clk_n(1);
      cyc12 = 1'b0; clk_n(31);
    end
    chk("steps_nfrq0", m_steps[0], 2);
    cyc12 = 1'b1;
    clk_n(600);

    // lowering the period mid-count must step on the very next tick
    do_reset();
    nfrq = '0;
    clk_n(20);
    chk("no_step_20", m_steps[0], 0);
    nfrq = {5'd31, 5'd31};
    clk_n(1);
    chk("step_on_change", m_steps[0], 1);
    clk_n(16);
    chk("bit_after_change", int'(noise_bit[0]), 1);

    // clock enable held off freezes everything
    ncen_n = 1'b1;
    for (int t = 0; t < 10; t++) begin
      cyc12 = t[0]; clk_n(1);
    end
    chk("freeze_steps", m_steps[0], 17);
    ncen_n = 1'b0; cyc12 = 1'b1;
    nfrq = {5'd3, 5'd9};
    clk_n(13);
    rst = 1'b1;
    clk_n(1);
    chk("midrst_acc0", int'(acc_noise[0 +: OUT_W]), 0);
    chk("midrst_acc1", int'(acc_noise[OUT_W +: OUT_W]), 0);
    chk("midrst_bits", int'(noise_bit), 0);
    rst = 1'b0;

    // two channels at different rates, only channel 1 audible
    nfrq = {5'd31, 5'd30}; ne = 2'b10; level = {13'h0100, 13'h0100};
    for (int t = 0; t < 40; t++) begin
      int a1;
      clk_n(1);
      a1 = int'(acc_noise[OUT_W +: OUT_W]);
      chk("ch0_silent", int'(acc_noise[0 +: OUT_W]), 0);
      chk("ch1_level", int'((a1 == 'h0100) || (a1 == 'h3F00)), 1);
    end
    chk("ch0_half_rate", m_steps[0], 20);

    // random traffic
    for (int t = 0; t < 6000; t++) begin
      rst    = ($urandom_range(0, 299) == 0);
      ncen_n = ($urandom_range(0, 5) == 0);
      cyc12  = ($urandom_range(0, 3) != 0);
      ne     = CH'($urandom);
      level  = (CH*MAG_W)'({$urandom, $urandom});
      if ($urandom_range(0, 49) == 0) begin
        for (int c = 0; c < CH; c++)
          nfrq[c*NFRQ_W +: NFRQ_W] = NFRQ_W'($urandom_range(20, 31));
      end
      clk_n(1);
    end

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/ika2151_noise_multi.md
Name: ika2151_noise_multi

Overview:
- Parametrised, multi-channel successor to the OPM noise generator.
- Each channel has its own frequency divider and LFSR, and a signed amplitude output stage that produces an accumulator-ready noise sample.
- Sits beside the operator pipeline and feeds the channel accumulator at the sample-frame tick.
- Adds per-channel enable, configurable LFSR width and taps, reset seed, zero-lockup recovery, and mid-count frequency-change safety.

Parameters:
CH, 1, number of independent noise channels
NFRQ_W, 5, width of the per-channel frequency code
LFSR_W, 17, LFSR length in bits (minimum 4)
TAP_A, 0, first feedback tap index
TAP_B, 3, second feedback tap index
SEED, 0, LFSR value loaded on reset (LFSR_W bits)
OUT_W, 14, signed output sample width

Ports:
i_EMUCLK  in  1  emulator master clock; the only clock
i_MRST  in  1  reset, synchronous, active-high
i_phi1_NCEN_n  in  1  phi1 clock enable, active-low; all state advances only when low
i_CYCLE_12  in  1  sample-frame tick strobe
i_NFRQ  in  CH*NFRQ_W  frequency code; channel c at [c*NFRQ_W +: NFRQ_W]
i_NE  in  CH  per-channel noise enable
i_LEVEL  in  CH*(OUT_W-1)  unsigned amplitude magnitude per channel
o_NOISE_BIT  out  CH  current LFSR[0] per channel
o_ACC_NOISE  out  CH*OUT_W  two's-complement noise sample; channel c at [c*OUT_W +: OUT_W]

Behaviour:
- One clock, i_EMUCLK. Reset i_MRST is synchronous and active-high; it has priority over the clock enable.
- Reset values, per channel:
  - cnt = 0
  - lfsr = SEED
  - acc register = 0
  - o_NOISE_BIT = SEED[0]
  - o_ACC_NOISE = 0
- tick = i_CYCLE_12 AND NOT i_phi1_NCEN_n. No state changes without a tick.
- Divider, per channel:
  - period = (2^NFRQ_W - 1) - NFRQ.
  - On tick: if cnt >= period, then cnt <= 0 and the LFSR steps; otherwise cnt <= cnt + 1.
  - Steps occur every period+1 ticks, e.g. NFRQ=31 gives every tick and NFRQ=0 gives every 32 ticks.
  - The compare is >=, never ==. If NFRQ changes so that period drops below cnt, the channel steps on the next tick with no counter wrap-around.
- LFSR step:
  - fb = lfsr[TAP_A] XOR lfsr[TAP_B].
  - Lockup recovery: if lfsr == 0, fb is forced to 1.
  - lfsr <= {fb, lfsr[LFSR_W-1:1]} (shift right, feedback into the MSB).
- o_NOISE_BIT = lfsr[0], taken directly from the register, so it is valid in the cycle after the step.
- Output stage, on every tick:
  - acc is sampled from the pre-step lfsr[0]. o_ACC_NOISE therefore lags the LFSR by one tick.
  - i_NE=0: acc <= 0.
  - i_NE=1, bit=1: acc <= +zero-extended i_LEVEL.
  - i_NE=1, bit=0: acc <= -zero-extended i_LEVEL, in OUT_W-bit two's complement.
  - The magnitude is OUT_W-1 bits wide, so the result never overflows.
- i_NE gates only the output. The divider and LFSR keep running while a channel is disabled.
- Channels are fully independent; there is no shared state between them.
- Reset asserted mid-count or mid-frame: all state returns to its reset value on the next clock edge, regardless of tick.

Test Plan:
- Reset then NFRQ=31, i_NE=1, LEVEL=0x1FFF, SEED=0 → the first tick steps the LFSR from 0 to 0x10000 via recovery, and o_ACC_NOISE=0x2001 (pre-step bit 0). After 16 more ticks the shifted 1 reaches bit 0: o_NOISE_BIT=1, and o_ACC_NOISE=0x1FFF one tick later.
- NFRQ=0 with ticks every 32 clocks → the LFSR steps exactly once every 32 ticks. The cnt sequence is 0..31, then 0.
- NFRQ=0, run 20 ticks, then set NFRQ=31 → the step occurs on the very next tick and cnt returns to 0, with no 2^NFRQ_W-tick stall.
- Hold i_phi1_NCEN_n high while i_CYCLE_12 pulses → cnt, lfsr and outputs stay frozen. Assert i_MRST mid-count → all channels show cnt=0, lfsr=SEED and o_ACC_NOISE=0 after one clock.
- CH=2, NFRQ={31,30}, i_NE={1,0}, LEVEL={0x0100,0x0100} → channel 1 steps every tick and outputs ±0x0100. Channel 0 steps every 2 ticks and outputs 0 throughout. Free-running 17-bit LFSR from 0x10000 returns to 0x10000 after 131071 steps.
